pwr_seq_ctrl: RTL
=================

// Module: pwr_seq_ctrl
// PURPOSE
//  Power-rail sequencer that consumes the 8-bit io register of the I2C slave expander.
//  Synchronises and filters io and rail power-good inputs into clk.
//  Enables rails in ascending order and disables them in descending order.
//  Latches faults on power-good timeout or loss.
// PARAMETERS
//  N_RAILS      4       number of sequenced rails (2..8)
//  SETTLE_CYC   1000    clk cycles between rail steps (after pgood up / after rail off)
//  TIMEOUT_CYC  100000  max clk cycles from rail_en[i] rise to pgood[i] high
//  FILT_CYC     4       consecutive identical samples needed to accept a new io value
//  CNT_W        17      timer width; must hold max(SETTLE_CYC,TIMEOUT_CYC)
// PORTS
//  clk         in   1        system clock
//  reset       in   1        synchronous, active-high reset
//  io          in   8        I2C expander outputs; asynchronous to clk, idles 8'hFF
//  pgood       in   N_RAILS  rail power-good, asynchronous, high = good
//  rail_en     out  N_RAILS  rail enables, high = on
//  pwr_ok      out  1        all rails up and settled
//  fault       out  1        latched fault flag
//  fault_rail  out  3        index of the rail that caused the fault
//  state_o     out  3        current FSM state encoding (debug)
// BEHAVIOUR
//  - Clocking/reset: one clock, clk; reset is synchronous, active-high.
//  - Reset values: rail_en=0, pwr_ok=0, fault=0, fault_rail=0, state=OFF.
//    Sync/filter flops reset to 1s (io) and 0s (pgood); timer=0, idx=0.
//    Reset mid-sequence turns all rails off on that same edge.
//  - io bit map (active-low, matching the 8'hFF idle state):
//    req = ~io_f[0]; clr = falling edge of io_f[7]; io[6:1] ignored.
//  - io path: 2-flop synchroniser, then filter.
//    io_f updates only after FILT_CYC equal consecutive synced samples.
//    Latency from a stable io change to io_f: 2+FILT_CYC cycles.
//  - pgood path: 2-flop synchroniser only, giving pgood_s (2-cycle latency).
//  - FSM states: OFF, UP_WAIT, UP_SETTLE, ON, DN_SETTLE, FAULT.
//    OFF:       req -> set idx=0, rail_en[0]=1, timer=0, go UP_WAIT.
//    UP_WAIT:   pgood_s[idx] -> UP_SETTLE, timer=0.
//               timer==TIMEOUT_CYC-1 -> FAULT with fault_rail=idx.
//               !req -> DN_SETTLE (rail idx stays on until its step).
//    UP_SETTLE: on timer==SETTLE_CYC-1: if idx==N_RAILS-1 go ON,
//               else idx++, set rail_en[idx], go UP_WAIT.
//               !req -> DN_SETTLE.
//               Loss of pgood_s on any enabled rail -> FAULT.
//    ON:        pwr_ok=1.
//               Any enabled rail with pgood_s low -> FAULT; fault_rail = lowest such index.
//               !req -> DN_SETTLE.
//    DN_SETTLE: on entry clear rail_en[idx], timer=0. On timer==SETTLE_CYC-1:
//               idx==0 -> OFF, else idx--, clear rail_en[idx], restart timer.
//               pgood is not checked; req re-asserted is ignored until OFF.
//    FAULT:     rail_en=0 and fault=1 from the transition edge; pwr_ok=0.
//               Leave to OFF only when clr is seen while req is inactive.
//               clr with req active is ignored; fault stays latched.
//  - Priority within a cycle: reset > fault condition > !req > timer expiry/progress.
//  - Timer saturates; it never wraps. idx never leaves 0..N_RAILS-1.
//  - pwr_ok is high only in ON. state_o is the registered state.
// STRUCTURE
//  - pwr_ctrl_defs.vh (shared include): FSM state encodings, IO_REQ_BIT=0,
//    IO_CLR_BIT=7, io idle value 8'hFF.
//  - Sub-module io_sync_filter #(W,FILT_CYC,RST_VAL): 2-flop sync + stability filter.
//    Used for io (FILT_CYC as set); pgood uses FILT_CYC=0 (bypass filter).
//  - Top level holds the FSM, timer, idx and output registers.
// TESTING (N_RAILS=4, SETTLE_CYC=8, TIMEOUT_CYC=32, FILT_CYC=4)
//  - Power-up: io 8'hFF->8'hFE, each pgood rises 5 cycles after its enable.
//    -> rail_en steps 0001,0011,0111,1111 in order; pwr_ok=1.
//    -> No rail enables before 2+4 cycles after the io change.
//  - Glitch rejection: io=8'hFE for 3 cycles, then back to 8'hFF.
//    -> rail_en stays 0000; state stays OFF.
//  - Timeout: pgood[2] never rises.
//    -> 32 cycles after rail_en[2] rises: rail_en=0000, fault=1, fault_rail=2.
//  - Loss in ON: drop pgood[1] for 1 cycle.
//    -> fault=1, fault_rail=1, rail_en=0000, pwr_ok=0.
//    -> io 8'hFF then 8'h7F clears to OFF; clr while io[0]=0 does not clear.
//  - Power-down: from ON set io=8'hFF.
//    -> rail_en 0111,0011,0001,0000, 8 cycles apart; state OFF; fault=0.
//  - Reset mid-UP_SETTLE, and req drop during UP_WAIT on rail 1:
//    -> reset zeroes all outputs on the same edge.
//    -> req drop takes DN_SETTLE path 0001 then 0000.

Source files
------------

// File: rtl/pwr_seq_ctrl_pkg.sv
// Shared definitions for the power-rail sequencer: FSM encodings and the
// expander io bit assignments.
package pwr_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_UP_WAIT   = 3'd1,
    ST_UP_SETTLE = 3'd2,
    ST_ON        = 3'd3,
    ST_DN_SETTLE = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam int         IO_REQ_BIT = 0;
  localparam int         IO_CLR_BIT = 7;
  localparam logic [7:0] IO_IDLE    = 8'hFF;

endpackage

// File: rtl/pwr_seq_ctrl_io_sync_filter.sv
// Two-flop synchroniser followed by an optional stability filter; a new value
// is accepted only after FILT_CYC identical consecutive synchronised samples.
module io_sync_filter #(
  parameter int           W        = 8,
  parameter int           FILT_CYC = 4,
  parameter logic [W-1:0] RST_VAL  = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_p0;
  logic [W-1:0] sync_p1;

  // stage 0/1: metastability capture
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  if (FILT_CYC == 0) begin : g_bypass
    assign q = sync_p1;
  end else begin : g_filt
    localparam int CW = $clog2(FILT_CYC + 1);

    logic [W-1:0]  cand;
    logic [W-1:0]  filt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] run;

    // Length of the current run of identical samples, including this one.
    always_comb begin
      run = CW'(1);
      if (sync_p1 == cand && cnt != '0) run = cnt + CW'(1);
    end

    // stage 2: accept the candidate once its run reaches FILT_CYC
    always_ff @(posedge clk) begin
      if (reset) begin
        filt <= RST_VAL;
        cand <= RST_VAL;
        cnt  <= '0;
      end else if (sync_p1 == filt) begin
        cnt <= '0;
      end else if (run == CW'(FILT_CYC)) begin
        filt <= sync_p1;
        cnt  <= '0;
      end else begin
        cand <= sync_p1;
        cnt  <= run;
      end
    end

    assign q = filt;
  end

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power-rail sequencer: ramps rails up in ascending order on request, down in
// descending order on release, and latches a fault on power-good timeout/loss.
module pwr_seq_ctrl
  import pwr_seq_ctrl_pkg::*;
#(
  parameter int N_RAILS     = 4,
  parameter int SETTLE_CYC  = 1000,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FILT_CYC    = 4,
  parameter int CNT_W       = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         io,
  input  logic [N_RAILS-1:0] pgood,
  output logic [N_RAILS-1:0] rail_en,
  output logic               pwr_ok,
  output logic               fault,
  output logic [2:0]         fault_rail,
  output logic [2:0]         state_o
);

  localparam int               IDX_W        = (N_RAILS > 2) ? $clog2(N_RAILS) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX    = '1;
  localparam logic [IDX_W-1:0] LAST_RAIL    = IDX_W'(N_RAILS - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   timer;
  logic [7:0]         io_f;
  logic [N_RAILS-1:0] pgood_s;
  logic [N_RAILS-1:0] lost;
  logic               clr_d;
  logic               req;
  logic               clr;
  logic               unused_io;

  io_sync_filter #(.W(8), .FILT_CYC(FILT_CYC), .RST_VAL(IO_IDLE)) u_io (
    .clk(clk), .reset(reset), .d(io), .q(io_f)
  );

  io_sync_filter #(.W(N_RAILS), .FILT_CYC(0), .RST_VAL({N_RAILS{1'b0}})) u_pg (
    .clk(clk), .reset(reset), .d(pgood), .q(pgood_s)
  );

  // Control bits are active-low so the idle expander value (all ones) means "off".
  assign req       = ~io_f[IO_REQ_BIT];
  assign clr       = clr_d & ~io_f[IO_CLR_BIT];
  assign unused_io = ^io_f[6:1];
  assign lost      = rail_en & ~pgood_s;
  assign state_o   = state;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] t);
    return (t == TIMER_MAX) ? t : t + CNT_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] lowest(input logic [N_RAILS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_RAILS - 1; i >= 0; i--) if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_OFF;
      rail_en    <= '0;
      pwr_ok     <= 1'b0;
      fault      <= 1'b0;
      fault_rail <= '0;
      timer      <= '0;
      idx        <= '0;
      clr_d      <= 1'b1;
    end else begin
      clr_d <= io_f[IO_CLR_BIT];
      timer <= sat_inc(timer);
      case (state)
        ST_OFF: begin
          if (req) begin
            idx     <= '0;
            rail_en <= N_RAILS'(1);
            timer   <= '0;
            state   <= ST_UP_WAIT;
          end
        end
        ST_UP_WAIT: begin
          if (!pgood_s[idx] && timer == TIMEOUT_LAST) begin
            state      <= ST_FAULT;
            rail_en    <= '0;
            fault      <= 1'b1;
            fault_rail <= 3'(idx);
            timer      <= '0;
          end else if (!req) begin
            state        <= ST_DN_SETTLE;
            rail_en[idx] <= 1'b0;
            timer        <= '0;
          end else if (pgood_s[idx]) begin
            state <= ST_UP_SETTLE;
            timer <= '0;
          end
        end
        ST_UP_SETTLE, ST_ON: begin
          if (lost != '0) begin
            state      <= ST_FAULT;
            rail_en    <= '0;
            fault      <= 1'b1;
            pwr_ok     <= 1'b0;
            fault_rail <= 3'(lowest(lost));
            timer      <= '0;
          end else if (!req) begin
            state        <= ST_DN_SETTLE;
            rail_en[idx] <= 1'b0;
            pwr_ok       <= 1'b0;
            timer        <= '0;
          end else if (state == ST_UP_SETTLE && timer == SETTLE_LAST) begin
            if (idx == LAST_RAIL) begin
              state  <= ST_ON;
              pwr_ok <= 1'b1;
            end else begin
              idx                         <= idx + IDX_W'(1);
              rail_en[idx + IDX_W'(1)]    <= 1'b1;
              timer                       <= '0;
              state                       <= ST_UP_WAIT;
            end
          end
        end
        ST_DN_SETTLE: begin
          if (timer == SETTLE_LAST) begin
            if (idx == '0) begin
              state <= ST_OFF;
            end else begin
              idx                      <= idx - IDX_W'(1);
              rail_en[idx - IDX_W'(1)] <= 1'b0;
              timer                    <= '0;
            end
          end
        end
        ST_FAULT: begin
          if (clr && !req) begin
            state      <= ST_OFF;
            fault      <= 1'b0;
            fault_rail <= '0;
            idx        <= '0;
            timer      <= '0;
          end
        end
        default: begin
          state   <= ST_OFF;
          rail_en <= '0;
          pwr_ok  <= 1'b0;
        end
      endcase
    end
  end

endmodule
